// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline: funct3 codes, data-memory base address,
// and the MEM/WB register layout.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [XLEN-1:0] DATA_BASE_ADDR_DEFAULT = 32'h1001_0000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } access_size_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       load_data;
    } memwb_t;

    // Unsigned variants only exist for loads; anything unrecognised is a word access.
    function automatic access_size_e decode_size(input logic [2:0] funct3, input logic is_store);
        access_size_e size;
        size = SizeWord;
        case (funct3)
            F3_B:    size = SizeByte;
            F3_H:    size = SizeHalf;
            F3_W:    size = SizeWord;
            F3_BU:   size = is_store ? SizeWord : SizeByte;
            F3_HU:   size = is_store ? SizeWord : SizeHalf;
            default: size = SizeWord;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM register contents as seen by the MEM stage.
interface mem_wb_stage_if;
    import riscv_pkg::*;

    logic                  exmem_valid_i;
    logic [XLEN-1:0]       exmem_alu_result_i;
    logic [XLEN-1:0]       exmem_store_data_i;
    logic [REG_ADDR_W-1:0] exmem_rd_i;
    logic [2:0]            exmem_funct3_i;
    logic                  exmem_reg_write_i;
    logic                  exmem_mem_to_reg_i;
    logic                  exmem_mem_read_i;
    logic                  exmem_mem_write_i;

    modport master (
        output exmem_valid_i,
        output exmem_alu_result_i,
        output exmem_store_data_i,
        output exmem_rd_i,
        output exmem_funct3_i,
        output exmem_reg_write_i,
        output exmem_mem_to_reg_i,
        output exmem_mem_read_i,
        output exmem_mem_write_i
    );

    modport slave (
        input exmem_valid_i,
        input exmem_alu_result_i,
        input exmem_store_data_i,
        input exmem_rd_i,
        input exmem_funct3_i,
        input exmem_reg_write_i,
        input exmem_mem_to_reg_i,
        input exmem_mem_read_i,
        input exmem_mem_write_i
    );

endinterface

// File: rtl/data_memory_bytewe.sv
// Word-organised data memory: synchronous byte-enable write, asynchronous read.
// Contents are deliberately not reset.
module data_memory_bytewe #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: data-memory access, load alignment/extension,
// register-file write-back and MEM-stage forwarding/hazard outputs.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     DATA_MEMORY_DEPTH = 128,
    parameter logic [XLEN-1:0] DATA_BASE_ADDR    = DATA_BASE_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_wb_stage_if.slave         exmem,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] mem_fwd_rd_o,
    output logic [XLEN-1:0]       mem_fwd_data_o,
    output logic                  mem_is_load_o,
    output logic                  wb_reg_write_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  misalign_o
);

    localparam int unsigned ADDR_W = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;

    logic [XLEN-1:0] addr;
    logic [1:0]      lane;
    logic [29:0]     word_off;
    logic            in_range;
    logic            misaligned;
    logic            access_err;
    logic            is_access;
    logic            sign_ext;
    access_size_e    size;

    logic [3:0]      lane_be;
    logic [3:0]      mem_be;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;
    logic [31:0]     shifted;
    logic [31:0]     load_data;
    logic            mem_we;

    memwb_t memwb_q, memwb_d;
    logic   misalign_q, misalign_d;

    assign addr     = exmem.exmem_alu_result_i;
    assign lane     = addr[1:0];
    // Word offset computed on bits [31:2] so addresses below the base wrap out of range.
    assign word_off = addr[31:2] - DATA_BASE_ADDR[31:2];
    assign in_range = word_off < 30'(DATA_MEMORY_DEPTH);
    assign size     = decode_size(exmem.exmem_funct3_i, exmem.exmem_mem_write_i);
    assign sign_ext = (exmem.exmem_funct3_i == F3_B) || (exmem.exmem_funct3_i == F3_H);

    always_comb begin
        misaligned = 1'b0;
        lane_be    = 4'hF;
        mem_wdata  = exmem.exmem_store_data_i;
        case (size)
            SizeByte: begin
                lane_be   = 4'b0001 << lane;
                mem_wdata = {4{exmem.exmem_store_data_i[7:0]}};
            end
            SizeHalf: begin
                misaligned = lane[0];
                lane_be    = 4'b0011 << {lane[1], 1'b0};
                mem_wdata  = {2{exmem.exmem_store_data_i[15:0]}};
            end
            default: begin
                misaligned = (lane != 2'b00);
            end
        endcase
    end

    assign access_err = !in_range || misaligned;
    assign is_access  = exmem.exmem_valid_i && (exmem.exmem_mem_read_i || exmem.exmem_mem_write_i);

    // Gating on reset drops any store sitting in EX/MEM while reset is held.
    assign mem_we = exmem.exmem_valid_i && exmem.exmem_mem_write_i && !stall_i && !flush_i &&
                    !access_err && reset;
    assign mem_be = mem_we ? lane_be : 4'b0000;

    data_memory_bytewe #(
        .DEPTH  (DATA_MEMORY_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk_i   (clk),
        .be_i    (mem_be),
        .addr_i  (word_off[ADDR_W-1:0]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign shifted = mem_rdata >> {lane, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            SizeByte: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SizeHalf: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
        if (access_err) begin
            load_data = '0;
        end
    end

    always_comb begin
        memwb_d = memwb_q;
        if (flush_i) begin
            memwb_d = '0;
        end else if (!stall_i) begin
            memwb_d.valid      = exmem.exmem_valid_i;
            memwb_d.rd         = exmem.exmem_rd_i;
            memwb_d.reg_write  = exmem.exmem_reg_write_i;
            memwb_d.mem_to_reg = exmem.exmem_mem_to_reg_i;
            memwb_d.alu_result = exmem.exmem_alu_result_i;
            memwb_d.load_data  = load_data;
        end
    end

    // Squashed (flushed) instructions do not raise the sticky error flag.
    assign misalign_d = misalign_q || (is_access && access_err && !flush_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memwb_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            memwb_q    <= memwb_d;
            misalign_q <= misalign_d;
        end
    end

    assign wb_reg_write_o = memwb_q.valid && memwb_q.reg_write && (memwb_q.rd != '0);
    assign wb_rd_o        = memwb_q.rd;
    assign wb_data_o      = memwb_q.mem_to_reg ? memwb_q.load_data : memwb_q.alu_result;
    assign misalign_o     = misalign_q;

    assign mem_fwd_rd_o   = (exmem.exmem_valid_i && exmem.exmem_reg_write_i &&
                             !exmem.exmem_mem_read_i && (exmem.exmem_rd_i != '0)) ?
                            exmem.exmem_rd_i : '0;
    assign mem_fwd_data_o = exmem.exmem_alu_result_i;
    assign mem_is_load_o  = exmem.exmem_valid_i && exmem.exmem_mem_read_i;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// checked against a byte-addressed memory model.
module tb_mem_wb_stage;
    import riscv_pkg::*;

    localparam logic [31:0] BASE      = 32'h1001_0000;
    localparam int          MEM_BYTES = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic [4:0]  mem_fwd_rd, wb_rd;
    logic [31:0] mem_fwd_data, wb_data;
    logic        mem_is_load, wb_reg_write, misalign;

    always #5 clk = ~clk;

    mem_wb_stage_if exmem_if ();

    mem_wb_stage #(
        .DATA_MEMORY_DEPTH (128),
        .DATA_BASE_ADDR    (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exmem          (exmem_if),
        .stall_i        (stall),
        .flush_i        (flush),
        .mem_fwd_rd_o   (mem_fwd_rd),
        .mem_fwd_data_o (mem_fwd_data),
        .mem_is_load_o  (mem_is_load),
        .wb_reg_write_o (wb_reg_write),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .misalign_o     (misalign)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  mbytes [MEM_BYTES];
    bit          exp_we  = 1'b0;
    bit          exp_mis = 1'b0;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3, input bit st);
        if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
        return 4;
    endfunction

    function automatic bit model_err(input logic [2:0] f3, input bit st, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off >= 32'(MEM_BYTES)) return 1'b1;
        return (int'(off) % size_of(f3, st)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int o, sz;
        logic [31:0] v;
        if (model_err(f3, 1'b0, a)) return 32'h0;
        o  = int'(a - BASE);
        sz = size_of(f3, 1'b0);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mbytes[o + i];
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz - 1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_instr(input bit v, input logic [31:0] a, input logic [31:0] sd,
                             input logic [4:0] rd, input logic [2:0] f3,
                             input bit rw, input bit mr, input bit mw);
        exmem_if.exmem_valid_i      = v;
        exmem_if.exmem_alu_result_i = a;
        exmem_if.exmem_store_data_i = sd;
        exmem_if.exmem_rd_i         = rd;
        exmem_if.exmem_funct3_i     = f3;
        exmem_if.exmem_reg_write_i  = rw;
        exmem_if.exmem_mem_to_reg_i = mr;
        exmem_if.exmem_mem_read_i   = mr;
        exmem_if.exmem_mem_write_i  = mw;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] val);
        set_instr(1'b1, val, 32'h0, rd, 3'd2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a);
        set_instr(1'b1, a, 32'h0, rd, f3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic set_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        set_instr(1'b1, a, d, 5'd0, f3, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_bubble();
        set_instr(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: model advances on the edge, outputs are then sampled 1ns later.
    task automatic tick();
        bit          v, rw, mr, mw, m2r, err;
        logic [31:0] a, sd, ld;
        logic [4:0]  rd;
        logic [2:0]  f3;
        int          o, sz;
        v   = exmem_if.exmem_valid_i;      a  = exmem_if.exmem_alu_result_i;
        sd  = exmem_if.exmem_store_data_i; rd = exmem_if.exmem_rd_i;
        f3  = exmem_if.exmem_funct3_i;     rw = exmem_if.exmem_reg_write_i;
        m2r = exmem_if.exmem_mem_to_reg_i; mr = exmem_if.exmem_mem_read_i;
        mw  = exmem_if.exmem_mem_write_i;
        err = model_err(f3, mw, a);
        ld  = model_load(f3, a);
        @(posedge clk);
        if (reset) begin
            if (v && mw && !stall && !flush && !err) begin
                o  = int'(a - BASE);
                sz = size_of(f3, 1'b1);
                for (int i = 0; i < sz; i++) mbytes[o + i] = sd[8*i +: 8];
            end
            if (v && (mr || mw) && err && !flush) exp_mis = 1'b1;
            if (flush) exp_we = 1'b0;
            else if (!stall) begin
                exp_we   = v && rw && (rd != 5'd0);
                exp_rd   = rd;
                exp_data = m2r ? ld : a;
            end
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_bubble();
        #12;
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset wb_reg_write got %b want 0", wb_reg_write); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset wb_rd got %0d want 0", wb_rd); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset wb_data got %h want 0", wb_data); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset misalign got %b want 0", misalign); end
        checks++; if (mem_is_load !== 1'b0) begin errors++; $display("FAIL reset mem_is_load got %b want 0", mem_is_load); end
        @(negedge clk) reset = 1'b1;
        tick();
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL post_reset wb_reg_write got %b want 0", wb_reg_write); end
    endtask

    task automatic init_mem();
        for (int w = 0; w < MEM_BYTES / 4; w++) begin
            set_store(F3_W, BASE + 32'(4 * w), 32'h0);
            tick();
        end
        set_bubble();
    endtask

    task automatic test_sw_lw();
        set_store(F3_W, BASE + 32'h4, 32'hDEAD_BEEF); tick();
        set_load(5'd7, F3_W, BASE + 32'h4); #1;
        checks++; if (mem_is_load !== 1'b1) begin errors++; $display("FAIL sw_lw mem_is_load got %b want 1", mem_is_load); end
        checks++; if (mem_fwd_rd !== 5'd0) begin errors++; $display("FAIL sw_lw load_fwd_rd got %0d want 0", mem_fwd_rd); end
        tick();
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL sw_lw wb_reg_write got %b want 1", wb_reg_write); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL sw_lw wb_rd got %0d want 7", wb_rd); end
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_lw wb_data got %h want deadbeef", wb_data); end
    endtask

    task automatic test_byte_lanes();
        set_store(F3_W, BASE, 32'h0); tick();
        set_store(F3_B, BASE + 32'h1, 32'h1234_5680); tick();
        set_load(5'd1, F3_B, BASE + 32'h1); tick();
        checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h want ffffff80", wb_data); end
        set_load(5'd2, F3_BU, BASE + 32'h1); tick();
        checks++; if (wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h want 00000080", wb_data); end
        set_load(5'd3, F3_W, BASE); tick();
        checks++; if (wb_data !== 32'h0000_8000) begin errors++; $display("FAIL lw_after_sb got %h want 00008000", wb_data); end
        set_load(5'd4, F3_H, BASE); tick();
        checks++; if (wb_data !== 32'hFFFF_8000) begin errors++; $display("FAIL lh got %h want ffff8000", wb_data); end
    endtask

    task automatic test_stall();
        stall = 1'b0; flush = 1'b0;
        set_alu(5'd9, 32'h55); tick();
        stall = 1'b1;
        set_store(F3_W, BASE + 32'h8, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h55) begin
                errors++; $display("FAIL stall_hold cyc%0d got we=%b rd=%0d data=%h want 1/9/55", i, wb_reg_write, wb_rd, wb_data);
            end
        end
        stall = 1'b0;
        set_load(5'd10, F3_W, BASE + 32'h8); tick();
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL stall_no_write got %h want 0", wb_data); end
        stall = 1'b1; set_store(F3_W, BASE + 32'h8, 32'hCAFE_F00D);
        repeat (3) tick();
        stall = 1'b0; tick();
        set_load(5'd10, F3_W, BASE + 32'h8); tick();
        checks++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_release_write got %h want cafef00d", wb_data); end
    endtask

    task automatic test_flush();
        set_alu(5'd11, 32'h77); tick();
        flush = 1'b1;
        set_store(F3_W, BASE + 32'hC, 32'h1234_5678); tick();
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_sw wb_reg_write got %b want 0", wb_reg_write); end
        set_alu(5'd5, 32'h99); #1;
        checks++; if (mem_fwd_rd !== 5'd5) begin errors++; $display("FAIL addi_fwd_rd got %0d want 5", mem_fwd_rd); end
        tick();
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_addi wb_reg_write got %b want 0", wb_reg_write); end
        flush = 1'b0;
        set_load(5'd12, F3_W, BASE + 32'hC); tick();
        checks++; if (wb_reg_write !== 1'b1 || wb_data !== 32'h0) begin
            errors++; $display("FAIL flush_no_write got we=%b data=%h want 1/0", wb_reg_write, wb_data);
        end
    endtask

    task automatic test_misalign();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_initial got %b want 0", misalign); end
        set_store(F3_W, BASE, 32'h1122_3344); tick();
        set_load(5'd3, F3_W, BASE + 32'h2); tick();
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got %b want 1", misalign); end
        checks++; if (wb_reg_write !== 1'b1 || wb_data !== 32'h0) begin
            errors++; $display("FAIL misalign_load got we=%b data=%h want 1/0", wb_reg_write, wb_data);
        end
        set_store(F3_W, BASE + 32'h2, 32'hFFFF_FFFF); tick();
        set_store(F3_H, BASE + 32'h1, 32'hFFFF_FFFF); tick();
        set_store(F3_W, BASE - 32'h4, 32'hFFFF_FFFF); tick();
        set_load(5'd4, F3_W, BASE); tick();
        checks++; if (wb_data !== 32'h1122_3344) begin errors++; $display("FAIL misalign_mem_unchanged got %h want 11223344", wb_data); end
        set_store(F3_W, BASE + 32'h1FC, 32'h5A5A_0001); tick();
        set_load(5'd5, F3_W, BASE + 32'h1FC); tick();
        checks++; if (wb_data !== 32'h5A5A_0001) begin errors++; $display("FAIL last_word got %h want 5a5a0001", wb_data); end
        set_load(5'd6, F3_W, BASE + 32'h200); tick();
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL out_of_range_load got %h want 0", wb_data); end
        set_bubble();
        repeat (5) tick();
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky got %b want 1", misalign); end
    endtask

    task automatic test_reset_mid();
        set_alu(5'd4, 32'h1); tick();
        set_store(F3_W, BASE + 32'h10, 32'hA5A5_A5A5);
        #2 reset = 1'b0;
        #1;
        exp_we = 1'b0; exp_mis = 1'b0;
        checks++; if (wb_reg_write !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0 || misalign !== 1'b0) begin
            errors++; $display("FAIL mid_reset got we=%b rd=%0d data=%h mis=%b want all 0", wb_reg_write, wb_rd, wb_data, misalign);
        end
        @(posedge clk);
        @(negedge clk);
        set_load(5'd8, F3_W, BASE + 32'h10);
        reset = 1'b1;
        tick();
        checks++; if (wb_reg_write !== 1'b1 || wb_data !== 32'h0) begin
            errors++; $display("FAIL reset_store_dropped got we=%b data=%h want 1/0", wb_reg_write, wb_data);
        end
        set_alu(5'd0, 32'h1234); #1;
        checks++; if (mem_fwd_rd !== 5'd0) begin errors++; $display("FAIL x0_fwd_rd got %0d want 0", mem_fwd_rd); end
        tick();
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL x0_wb_reg_write got %b want 0", wb_reg_write); end
    endtask

    task automatic test_random();
        int          kind, r, sz, t;
        bit          st;
        logic [4:0]  rd, want_fwd;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            rd   = 5'($urandom);
            st   = (kind >= 8);
            if (st) f3 = ($urandom_range(0, 5) == 0) ? 3'd4 : 3'($urandom_range(0, 2));
            else if ($urandom_range(0, 7) == 0) f3 = 3'd3;
            else begin t = $urandom_range(0, 4); f3 = 3'((t < 3) ? t : t + 1); end
            sz = size_of(f3, st);
            r  = $urandom_range(0, 15);
            if (r == 0)      a = BASE + 32'h200 + 32'(4 * $urandom_range(0, 7));
            else if (r == 1) a = BASE - 32'h4;
            else if (r == 2) a = BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
            else             a = BASE + 32'(4 * $urandom_range(0, 15) + sz * $urandom_range(0, 4 / sz - 1));
            if (kind < 2)      set_instr(1'b0, a, $urandom, rd, f3, 1'b1, 1'($urandom), 1'($urandom));
            else if (kind < 5) set_alu(rd, $urandom);
            else if (kind < 8) set_load(rd, f3, a);
            else               set_store(f3, a, $urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            want_fwd = (exmem_if.exmem_valid_i && exmem_if.exmem_reg_write_i &&
                        !exmem_if.exmem_mem_read_i && rd != 5'd0) ? rd : 5'd0;
            checks++; if (mem_fwd_rd !== want_fwd) begin errors++; $display("FAIL rand_fwd_rd n=%0d got %0d want %0d", n, mem_fwd_rd, want_fwd); end
            checks++; if (mem_is_load !== (exmem_if.exmem_valid_i && exmem_if.exmem_mem_read_i)) begin
                errors++; $display("FAIL rand_is_load n=%0d got %b", n, mem_is_load);
            end
            tick();
            checks++; if (wb_reg_write !== exp_we) begin errors++; $display("FAIL rand_we n=%0d got %b want %b", n, wb_reg_write, exp_we); end
            if (exp_we) begin
                checks++; if (wb_rd !== exp_rd || wb_data !== exp_data) begin
                    errors++; $display("FAIL rand_wb n=%0d got rd=%0d data=%h want rd=%0d data=%h", n, wb_rd, wb_data, exp_rd, exp_data);
                end
            end
            checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rand_misalign n=%0d got %b want %b", n, misalign, exp_mis); end
        end
        stall = 1'b0; flush = 1'b0;
        set_bubble();
    endtask

    initial begin
        test_reset();
        init_mem();
        test_sw_lw();
        test_byte_lanes();
        test_stall();
        test_flush();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
